// File: rtl/jtcps1_stars_arb.sv
// jtcps1_stars_arb: round-robin arbiter sharing one star ROM port between two star layers, with per-layer data buffers.
// Define JTCPS1_STARS_ARB_BURST_EN to let a grantee keep the port for up to 16 consecutive words.
module jtcps1_stars_arb #(
  parameter int AW   = 13,
  parameter int DW   = 32,
  parameter int TOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs0,
  input  logic [AW-1:0] addr0,
  output logic [DW-1:0] data0,
  output logic          ok0,
  input  logic          cs1,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] data1,
  output logic          ok1,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output logic          tout_err
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state_q, state_d;
  logic rom_cs_q, rom_cs_d, valid0_q, valid0_d, valid1_q, valid1_d;
  logic last_q, last_d, gnt_q, gnt_d, tout_err_q, tout_err_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d, tag0_q, tag0_d, tag1_q, tag1_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [5:0] timer_q, timer_d;
  logic need0, need1, g, cs_g;
  logic [AW-1:0] addr_g;
`ifdef JTCPS1_STARS_ARB_BURST_EN
  logic [3:0] burst_q, burst_d;
  logic started_q, started_d, keep;
`endif
  assign ok0      = cs0 & valid0_q & (addr0 == tag0_q);
  assign ok1      = cs1 & valid1_q & (addr1 == tag1_q);
  assign need0    = cs0 & ~ok0;
  assign need1    = cs1 & ~ok1;
  assign cs_g     = gnt_q ? cs1 : cs0;
  assign addr_g   = gnt_q ? addr1 : addr0;
  assign data0    = data0_q;
  assign data1    = data1_q;
  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;
  assign tout_err = tout_err_q;
`ifdef JTCPS1_STARS_ARB_BURST_EN
  assign keep = started_q & (last_q ? need1 : need0) & (burst_q != 4'd15);
  assign g    = keep ? last_q : (need0 & need1) ? ~last_q : need1;
`else
  assign g    = (need0 & need1) ? ~last_q : need1;
`endif
  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    tag0_d     = tag0_q;
    tag1_d     = tag1_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    timer_d    = timer_q;
    tout_err_d = 1'b0;
`ifdef JTCPS1_STARS_ARB_BURST_EN
    burst_d    = burst_q;
    started_d  = started_q;
`endif
    case (state_q)
      IDLE: if (need0 | need1) begin
        rom_addr_d = g ? addr1 : addr0;
        rom_cs_d   = 1'b1;
        valid0_d   = g ? valid0_q : 1'b0;
        valid1_d   = g ? 1'b0 : valid1_q;
        gnt_d      = g;
        last_d     = g;
        timer_d    = '0;
        state_d    = REQ;
`ifdef JTCPS1_STARS_ARB_BURST_EN
        burst_d    = (g == last_q) ? burst_q + 4'd1 : 4'd0;
        started_d  = 1'b1;
`endif
      end
      REQ: if (!cs_g || addr_g != rom_addr_q) begin
        rom_cs_d = 1'b0;
        state_d  = GAP;
      end else if (rom_ok) begin
        data0_d  = gnt_q ? data0_q : rom_data;
        tag0_d   = gnt_q ? tag0_q : rom_addr_q;
        valid0_d = gnt_q ? valid0_q : 1'b1;
        data1_d  = gnt_q ? rom_data : data1_q;
        tag1_d   = gnt_q ? rom_addr_q : tag1_q;
        valid1_d = gnt_q ? 1'b1 : valid1_q;
        rom_cs_d = 1'b0;
        state_d  = GAP;
      end else if (timer_q == 6'(TOUT)) begin
        tout_err_d = 1'b1;
        rom_cs_d   = 1'b0;
        state_d    = GAP;
      end else begin
        timer_d = timer_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      timer_q    <= '0;
      tout_err_q <= 1'b0;
`ifdef JTCPS1_STARS_ARB_BURST_EN
      burst_q    <= '0;
      started_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      timer_q    <= timer_d;
      tout_err_q <= tout_err_d;
`ifdef JTCPS1_STARS_ARB_BURST_EN
      burst_q    <= burst_d;
      started_q  <= started_d;
`endif
    end
  end
endmodule

// File: tb/tb_jtcps1_stars_arb.sv
// tb_jtcps1_stars_arb: ROM model plus access-order scoreboard and table-driven buffer checks for the star ROM arbiter.
module tb_jtcps1_stars_arb;
  localparam int AW = 13, DW = 32;
  logic clk = 0, rst = 1;
  logic cs0 = 0, cs1 = 0, ok0, ok1, rom_cs, rom_ok, tout_err;
  logic [AW-1:0] addr0 = 0, addr1 = 0, rom_addr;
  logic [DW-1:0] data0, data1, rom_data = 0, saved;
  logic auto_q = 0, auto_en = 1, force_ok = 0, prev_cs = 0;
  logic [AW-1:0] exp_q[$];
  int checks = 0, errors = 0;
  typedef struct {
    logic c0; logic [AW-1:0] a0; logic c1; logic [AW-1:0] a1; logic e0; logic e1;
  } vec_t;
  vec_t tbl[6];

  jtcps1_stars_arb dut (
    .clk(clk), .rst(rst), .cs0(cs0), .addr0(addr0), .data0(data0), .ok0(ok0),
    .cs1(cs1), .addr1(addr1), .data1(data1), .ok1(ok1), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {a, 6'h2a, ~a};
  endfunction

  // ROM answers on alternate cycles while selected; force_ok injects a stray pulse
  assign rom_ok = (auto_q & auto_en) | force_ok;
  always @(posedge clk) begin
    auto_q   <= rom_cs & ~auto_q;
    rom_data <= rom_fn(rom_addr);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // every new ROM access must match the next expected address
  always @(negedge clk) begin
    if (rom_cs && !prev_cs) begin
      chk("access_queued", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("access_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
    end
    prev_cs <= rom_cs;
  end

  task automatic wait_for(input int sel, input string nm);
    int n = 0;
    logic hit = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      hit = (sel == 0) ? ok0 : (sel == 1) ? ok1 : rom_cs;
      n++;
    end
    chk(nm, 32'(hit), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0, n1;
    tbl[0] = '{1, 13'h0123, 1, 13'h1abc, 1, 1};
    tbl[1] = '{0, 13'h0123, 1, 13'h1abc, 0, 1};
    tbl[2] = '{0, 13'h0124, 0, 13'h1abc, 0, 0};
    tbl[3] = '{1, 13'h0123, 0, 13'h1abd, 1, 0};
    tbl[4] = '{0, 13'h0000, 0, 13'h0000, 0, 0};
    tbl[5] = '{1, 13'h0123, 1, 13'h1abc, 1, 1};
    repeat (3) @(negedge clk);
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    chk("rst_tout", 32'(tout_err), 0);
    rst = 0;
    // single requester
    @(negedge clk);
    cs0 = 1; addr0 = 13'h0123; exp_q.push_back(13'h0123);
    @(negedge clk);
    chk("single_cs", 32'(rom_cs), 1);
    chk("single_ok0_early", 32'(ok0), 0);
    @(negedge clk);
    chk("single_rom_ok", 32'(rom_ok), 1);
    chk("single_ok0_wait", 32'(ok0), 0);
    @(negedge clk);
    chk("single_ok0", 32'(ok0), 1);
    chk("single_data0", data0, rom_fn(13'h0123));
    chk("single_ok1", 32'(ok1), 0);
    chk("single_cs_drop", 32'(rom_cs), 0);
    // load requester 1, then table of combinational buffer lookups
    cs1 = 1; addr1 = 13'h1abc; exp_q.push_back(13'h1abc);
    wait_for(1, "load1_ok");
    chk("load1_data", data1, rom_fn(13'h1abc));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cs0 = tbl[i].c0; addr0 = tbl[i].a0; cs1 = tbl[i].c1; addr1 = tbl[i].a1;
      #1;
      chk($sformatf("tbl%0d_ok0", i), 32'(ok0), 32'(tbl[i].e0));
      chk($sformatf("tbl%0d_ok1", i), 32'(ok1), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d_cs", i), 32'(rom_cs), 0);
      if (tbl[i].e0) chk($sformatf("tbl%0d_d0", i), data0, rom_fn(13'h0123));
    end
    // buffer hold across a long cs drop
    @(negedge clk);
    cs0 = 0;
    repeat (10) @(negedge clk);
    cs0 = 1; addr0 = 13'h0123;
    #1 chk("hold_ok0", 32'(ok0), 1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_cs", 32'(rom_cs), 0);
    end
    // contention from reset
    @(negedge clk);
    rst = 1; cs0 = 1; cs1 = 1; addr0 = 13'h0010; addr1 = 13'h1010;
    @(negedge clk);
    rst = 0;
`ifdef JTCPS1_STARS_ARB_BURST_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(13'h0010 + 13'(k));
    for (int k = 0; k < 4; k++) exp_q.push_back(13'h1010 + 13'(k));
`else
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(13'h0010 + 13'(k));
      exp_q.push_back(13'h1010 + 13'(k));
    end
`endif
    n0 = 0; n1 = 0;
    for (int c = 0; c < 200 && !(n0 == 3 && n1 == 3 && ok0 && ok1); c++) begin
      @(negedge clk);
      if (ok0 && n0 < 3) begin addr0 = addr0 + 1; n0++; end
      if (ok1 && n1 < 3) begin addr1 = addr1 + 1; n1++; end
    end
    chk("cont_pending", 32'(exp_q.size()), 0);
    chk("cont_ok", {30'd0, ok0, ok1}, 3);
    chk("cont_d0", data0, rom_fn(13'h0013));
    chk("cont_d1", data1, rom_fn(13'h1013));
    // abort: address changes while rom_ok arrives
    @(negedge clk);
    auto_en = 0; addr0 = 13'h0005; exp_q.push_back(13'h0005);
    wait_for(2, "abort_cs");
    saved = data0;
    addr0 = 13'h0006; force_ok = 1; exp_q.push_back(13'h0006);
    @(negedge clk);
    force_ok = 0; auto_en = 1;
    chk("abort_data0", data0, saved);
    chk("abort_ok0", 32'(ok0), 0);
    chk("abort_gap", 32'(rom_cs), 0);
    wait_for(0, "abort_ok_new");
    chk("abort_data_new", data0, rom_fn(13'h0006));
    // timeout on requester 0, then requester 1 is served
    @(negedge clk);
    auto_en = 0; addr0 = 13'h0007; exp_q.push_back(13'h0007);
    wait_for(2, "tout_cs");
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (!rom_cs) break;
      n++;
    end
    chk("tout_cycles", 32'(n), 64);
    chk("tout_pulse", 32'(tout_err), 1);
    chk("tout_ok0", 32'(ok0), 0);
    addr1 = 13'h0999; exp_q.push_back(13'h0999); exp_q.push_back(13'h0007);
    auto_en = 1;
    @(negedge clk);
    chk("tout_pulse_end", 32'(tout_err), 0);
    wait_for(1, "tout_ok1");
    chk("tout_data1", data1, rom_fn(13'h0999));
    wait_for(0, "tout_retry_ok0");
    chk("tout_data0", data0, rom_fn(13'h0007));
    // reset in the middle of an access
    @(negedge clk);
    addr0 = 13'h0100; exp_q.push_back(13'h0100);
    wait_for(2, "rst_req_cs");
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstreq_cs", 32'(rom_cs), 0);
    chk("rstreq_ok", {30'd0, ok0, ok1}, 0);
    chk("rstreq_data0", data0, 0);
    exp_q.push_back(13'h0100); exp_q.push_back(13'h0999);
    wait_for(0, "rstreq_ok0");
    chk("rstreq_d0", data0, rom_fn(13'h0100));
    wait_for(1, "rstreq_ok1");
    chk("rstreq_d1", data1, rom_fn(13'h0999));
    repeat (2) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
